// File: rtl/muldiv_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : muldiv_sequencer
// Brief    : EX-stage sequencer for HI/LO multiply and 32-step restoring divide.
//            Optional macro DIVZERO_FAST_EN: a zero divisor completes in one cycle.
// Revision : 1.0
// =============================================================================
module muldiv_sequencer #(
    parameter int         MUL_LAT   = 4,
    parameter logic [5:0] ALU_MULT  = 6'd24,
    parameter logic [5:0] ALU_MULTU = 6'd25,
    parameter logic [5:0] ALU_DIV   = 6'd26,
    parameter logic [5:0] ALU_DIVU  = 6'd27,
    parameter logic [5:0] ALU_MUL   = 6'd28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  aluop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic        hilo_we,
    output logic        gpr_we,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_mul_last = 4'(MUL_LAT - 1);

    state_t      r_state;
    logic [31:0] r_a;          // multiplicand, or dividend shifting into quotient
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic [3:0]  r_mul_cnt;
    logic        r_signed;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_gpr;
    logic        r_done;
    logic        r_hilo_we;
    logic        r_gpr_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_sgn;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_is_mul = (aluop == ALU_MULT) || (aluop == ALU_MULTU) || (aluop == ALU_MUL);
    assign w_is_div = (aluop == ALU_DIV) || (aluop == ALU_DIVU);
    assign w_sgn    = (aluop == ALU_MULT) || (aluop == ALU_MUL) || (aluop == ALU_DIV);
    assign w_accept = (r_state == S_IDLE) && start && !flush && (w_is_mul || w_is_div);

    assign w_abs_a = (w_sgn && src_a[31]) ? -src_a : src_a;
    assign w_abs_b = (w_sgn && src_b[31]) ? -src_b : src_b;

    // Operands widened to 64 bits so one unsigned multiplier serves both signednesses
    assign w_ext_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // 33-bit trial keeps divisors above 2^31 correct
    assign w_trial  = {r_rem, r_a[31]};
    assign w_ge     = (w_trial >= {1'b0, r_b});
    assign w_rem_nx = w_ge ? 32'(w_trial - {1'b0, r_b}) : w_trial[31:0];
    assign w_quo_nx = {r_a[30:0], w_ge};
    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rem     <= 32'd0;
            r_cnt     <= 5'd0;
            r_mul_cnt <= 4'd0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_gpr     <= 1'b0;
            r_done    <= 1'b0;
            r_hilo_we <= 1'b0;
            r_gpr_we  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done    <= 1'b0;
            r_hilo_we <= 1'b0;
            r_gpr_we  <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_signed  <= w_sgn;
                            r_gpr     <= (aluop == ALU_MUL);
                            r_neg_q   <= w_sgn && (src_a[31] ^ src_b[31]);
                            r_neg_r   <= w_sgn && src_a[31];
                            r_rem     <= 32'd0;
                            r_cnt     <= 5'd0;
                            r_mul_cnt <= 4'd0;
                            if (w_is_mul) begin
                                r_a     <= src_a;
                                r_b     <= src_b;
                                r_state <= S_MUL;
                            end else begin
                                r_a <= w_abs_a;
                                r_b <= w_abs_b;
`ifdef DIVZERO_FAST_EN
                                // Zero divisor: all quotient bits are 1, remainder is |a|
                                if (src_b == 32'd0) begin
                                    r_state   <= S_DONE;
                                    r_hi      <= src_a;
                                    r_lo      <= (w_sgn && src_a[31]) ? 32'd1 : 32'hFFFF_FFFF;
                                    r_done    <= 1'b1;
                                    r_hilo_we <= 1'b1;
                                end else begin
                                    r_state <= S_DIV;
                                end
`else
                                r_state <= S_DIV;
`endif
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_mul_cnt == c_mul_last) begin
                            r_state   <= S_DONE;
                            r_hi      <= w_prod[63:32];
                            r_lo      <= w_prod[31:0];
                            r_done    <= 1'b1;
                            r_gpr_we  <= r_gpr;
                            r_hilo_we <= !r_gpr;
                        end else begin
                            r_mul_cnt <= r_mul_cnt + 4'd1;
                        end
                    end
                    S_DIV: begin
                        r_a   <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state   <= S_DONE;
                            r_hi      <= w_r_fix;
                            r_lo      <= w_q_fix;
                            r_done    <= 1'b1;
                            r_hilo_we <= 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign stall   = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    assign done    = r_done && !flush;
    assign hilo_we = r_hilo_we && !flush;
    assign gpr_we  = r_gpr_we && !flush;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire
